// File: rtl/peak_report_pkg.sv
// Shared types and constants for the peak report arbiter and its channel FIFOs.
// peak_entry_t documents the queued record layout at the default peak_finder widths.
package peak_report_pkg;

    typedef enum logic {
        CH_I = 1'b0,
        CH_Q = 1'b1
    } chan_e;

    localparam int SEQ_LEN       = 15;
    localparam int TUSER_LEN     = 16;
    localparam int DEF_INDEX_LEN = 32;
    localparam int DEF_DATA_LEN  = 64;

    typedef struct packed {
        logic [DEF_INDEX_LEN-1:0] index;
        logic [DEF_DATA_LEN-1:0]  data;
        logic [SEQ_LEN-1:0]       seq;
    } peak_entry_t;

endpackage

// File: rtl/peak_report_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is accepted
// when a pop happens in the same cycle.
module peak_report_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage is left unreset: the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/peak_report_arbiter.sv
// Merges I/Q peak_finder results into one AXI-Stream report stream with
// channel/sequence tags, round-robin arbitration and per-channel drop counters.
module peak_report_arbiter
    import peak_report_pkg::*;
#(
    parameter int INDEX_LEN = 32,
    parameter int DATA_LEN  = 64,
    parameter int DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic                          enable,
    input  logic [INDEX_LEN-1:0]          peak_index_i,
    input  logic [DATA_LEN-1:0]           peak_tdata_i,
    input  logic                          peak_tvalid_i,
    input  logic [INDEX_LEN-1:0]          peak_index_q,
    input  logic [DATA_LEN-1:0]           peak_tdata_q,
    input  logic                          peak_tvalid_q,
    output logic [DATA_LEN+INDEX_LEN-1:0] m_axis_tdata,
    output logic [TUSER_LEN-1:0]          m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [15:0]                   drop_count_i,
    output logic [15:0]                   drop_count_q
);

    localparam int ENTRY_W = INDEX_LEN + DATA_LEN + SEQ_LEN;
    localparam logic [SEQ_LEN-1:0] SEQ_ONE  = 1;
    localparam logic [15:0]        DROP_ONE = 1;
    localparam logic [15:0]        DROP_MAX = 16'hFFFF;

    logic [SEQ_LEN-1:0]            r_seq_i;
    logic [SEQ_LEN-1:0]            r_seq_q;
    logic [15:0]                   r_drop_i;
    logic [15:0]                   r_drop_q;
    chan_e                         r_last;
    logic                          r_valid;
    logic [DATA_LEN+INDEX_LEN-1:0] r_tdata;
    logic [TUSER_LEN-1:0]          r_tuser;

    logic               w_cap_i;
    logic               w_cap_q;
    logic [ENTRY_W-1:0] w_data_i;
    logic [ENTRY_W-1:0] w_data_q;
    logic               w_full_i;
    logic               w_full_q;
    logic               w_empty_i;
    logic               w_empty_q;
    logic               w_load;
    logic               w_tie;
    chan_e              w_sel;
    logic               w_pop_i;
    logic               w_pop_q;
    logic               w_drop_i;
    logic               w_drop_q;
    logic [ENTRY_W-1:0] w_src;

    assign w_cap_i = peak_tvalid_i && enable;
    assign w_cap_q = peak_tvalid_q && enable;

    peak_report_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo_i (
        .clk     (clk),
        .aresetn (aresetn),
        .i_push  (w_cap_i),
        .i_data  ({peak_index_i, peak_tdata_i, r_seq_i}),
        .i_pop   (w_pop_i),
        .o_data  (w_data_i),
        .o_full  (w_full_i),
        .o_empty (w_empty_i)
    );

    peak_report_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo_q (
        .clk     (clk),
        .aresetn (aresetn),
        .i_push  (w_cap_q),
        .i_data  ({peak_index_q, peak_tdata_q, r_seq_q}),
        .i_pop   (w_pop_q),
        .o_data  (w_data_q),
        .o_full  (w_full_q),
        .o_empty (w_empty_q)
    );

    // The output register accepts a new report whenever it is empty or being drained.
    assign w_load = !r_valid || m_axis_tready;

    // Only a genuine tie moves the grant pointer, so repeated ties alternate.
    always_comb begin
        w_sel   = CH_I;
        w_tie   = 1'b0;
        w_pop_i = 1'b0;
        w_pop_q = 1'b0;
        if (w_load) begin
            if (!w_empty_i && !w_empty_q) begin
                w_tie = 1'b1;
                w_sel = (r_last == CH_I) ? CH_Q : CH_I;
            end else if (!w_empty_q) begin
                w_sel = CH_Q;
            end
            w_pop_i = !w_empty_i && (w_sel == CH_I);
            w_pop_q = !w_empty_q && (w_sel == CH_Q);
        end
    end

    assign w_src    = (w_sel == CH_Q) ? w_data_q : w_data_i;
    assign w_drop_i = w_cap_i && w_full_i && !w_pop_i;
    assign w_drop_q = w_cap_q && w_full_q && !w_pop_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid <= 1'b0;
            r_tdata <= '0;
            r_tuser <= '0;
            r_last  <= CH_Q;
        end else begin
            if (w_pop_i || w_pop_q) begin
                r_valid <= 1'b1;
                r_tdata <= w_src[ENTRY_W-1:SEQ_LEN];
                r_tuser <= {w_sel, w_src[SEQ_LEN-1:0]};
            end else if (r_valid && m_axis_tready) begin
                r_valid <= 1'b0;
            end
            if (w_tie) r_last <= w_sel;
        end
    end

    // Sequence numbers advance on every enabled pulse, so dropped reports leave gaps.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_seq_i  <= '0;
            r_seq_q  <= '0;
            r_drop_i <= '0;
            r_drop_q <= '0;
        end else begin
            if (w_cap_i) r_seq_i <= r_seq_i + SEQ_ONE;
            if (w_cap_q) r_seq_q <= r_seq_q + SEQ_ONE;
            if (w_drop_i && (r_drop_i != DROP_MAX)) r_drop_i <= r_drop_i + DROP_ONE;
            if (w_drop_q && (r_drop_q != DROP_MAX)) r_drop_q <= r_drop_q + DROP_ONE;
        end
    end

    assign m_axis_tvalid = r_valid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tuser  = r_tuser;
    assign drop_count_i  = r_drop_i;
    assign drop_count_q  = r_drop_q;

endmodule

// File: tb/tb_peak_report_arbiter.sv
// Self-checking bench for peak_report_arbiter: directed vector table, hand
// sequences for stall/reset/saturation, and a queue-based scoreboard model.
module tb_peak_report_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic [31:0] peak_index_i;
    logic [63:0] peak_tdata_i;
    logic        peak_tvalid_i;
    logic [31:0] peak_index_q;
    logic [63:0] peak_tdata_q;
    logic        peak_tvalid_q;
    logic [95:0] m_axis_tdata;
    logic [15:0] m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [15:0] drop_count_i;
    logic [15:0] drop_count_q;

    peak_report_arbiter #(.INDEX_LEN(32), .DATA_LEN(64), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .enable        (enable),
        .peak_index_i  (peak_index_i),
        .peak_tdata_i  (peak_tdata_i),
        .peak_tvalid_i (peak_tvalid_i),
        .peak_index_q  (peak_index_q),
        .peak_tdata_q  (peak_tdata_q),
        .peak_tvalid_q (peak_tvalid_q),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .drop_count_i  (drop_count_i),
        .drop_count_q  (drop_count_q)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chan;
        logic [14:0] seq;
        logic [31:0] idx;
        logic [63:0] dat;
    } rep_t;

    typedef struct packed {
        logic        vi;
        logic        vq;
        logic        en;
        logic        rdy;
        logic [31:0] ii;
        logic [63:0] di;
        logic [31:0] iq;
        logic [63:0] dq;
        logic        ev;
        logic [95:0] etd;
        logic [15:0] etu;
    } vec_t;

    int   nChecks = 0;
    int   nFail   = 0;
    rep_t mqI[$];
    rep_t mqQ[$];
    rep_t sb[$];
    logic        mLast;
    logic [14:0] msI;
    logic [14:0] msQ;
    logic [15:0] mdI;
    logic [15:0] mdQ;
    logic        lastSeqValid;
    logic [14:0] lastSeqI;
    int          wrapSeen;
    vec_t        vecs [18];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mqI.delete();
        mqQ.delete();
        sb.delete();
        mLast        = 1'b1;
        msI          = '0;
        msQ          = '0;
        mdI          = '0;
        mdQ          = '0;
        lastSeqValid = 1'b0;
        lastSeqI     = '0;
    endtask

    task automatic resetDut();
        peak_tvalid_i = 1'b0;
        peak_tvalid_q = 1'b0;
        m_axis_tready = 1'b0;
        aresetn       = 1'b0;
        #2;
        chk("rst_tvalid", 128'(m_axis_tvalid), 128'(1'b0));
        chk("rst_tdata",  128'(m_axis_tdata),  128'(96'h0));
        chk("rst_tuser",  128'(m_axis_tuser),  128'(16'h0));
        chk("rst_drop_i", 128'(drop_count_i),  128'(16'h0));
        chk("rst_drop_q", 128'(drop_count_q),  128'(16'h0));
        modelReset();
        @(posedge clk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic checkOutput();
        chk("tvalid", 128'(m_axis_tvalid), 128'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("tdata", 128'(m_axis_tdata), 128'({sb[0].idx, sb[0].dat}));
            chk("tuser", 128'(m_axis_tuser), 128'({sb[0].chan, sb[0].seq}));
        end
        chk("drop_i", 128'(drop_count_i), 128'(mdI));
        chk("drop_q", 128'(drop_count_q), 128'(mdQ));
    endtask

    task automatic applyStimulus(input logic vi, input logic vq, input logic en, input logic rdy,
                                 input logic [31:0] ii, input logic [63:0] di,
                                 input logic [31:0] iq, input logic [63:0] dq);
        rep_t e;
        rep_t p;
        logic fullI;
        logic fullQ;
        logic popI;
        logic popQ;
        logic sel;
        peak_tvalid_i = vi;
        peak_index_i  = ii;
        peak_tdata_i  = di;
        peak_tvalid_q = vq;
        peak_index_q  = iq;
        peak_tdata_q  = dq;
        enable        = en;
        m_axis_tready = rdy;
        if (m_axis_tvalid && rdy && !m_axis_tuser[15]) begin
            if (lastSeqValid && lastSeqI == 15'h7FFF) begin
                chk("seq_wrap", 128'(m_axis_tuser), 128'(16'h0000));
                wrapSeen++;
            end
            lastSeqI     = m_axis_tuser[14:0];
            lastSeqValid = 1'b1;
        end
        fullI = (mqI.size() == DEPTH);
        fullQ = (mqQ.size() == DEPTH);
        popI  = 1'b0;
        popQ  = 1'b0;
        if (sb.size() != 0 && rdy) void'(sb.pop_front());
        if (sb.size() == 0 && (mqI.size() != 0 || mqQ.size() != 0)) begin
            if (mqI.size() != 0 && mqQ.size() != 0) begin
                sel   = ~mLast;
                mLast = sel;
            end else begin
                sel = (mqQ.size() != 0);
            end
            if (sel) begin
                p    = mqQ.pop_front();
                popQ = 1'b1;
            end else begin
                p    = mqI.pop_front();
                popI = 1'b1;
            end
            sb.push_back(p);
        end
        if (vi && en) begin
            e.chan = 1'b0; e.seq = msI; e.idx = ii; e.dat = di;
            msI = msI + 15'd1;
            if (!fullI || popI) mqI.push_back(e);
            else if (mdI != 16'hFFFF) mdI = mdI + 16'd1;
        end
        if (vq && en) begin
            e.chan = 1'b1; e.seq = msQ; e.idx = iq; e.dat = dq;
            msQ = msQ + 15'd1;
            if (!fullQ || popQ) mqQ.push_back(e);
            else if (mdQ != 16'hFFFF) mdQ = mdQ + 16'd1;
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic stepIdle(input logic rdy, input logic en);
        applyStimulus(1'b0, 1'b0, en, rdy, 32'h0, 64'h0, 32'h0, 64'h0);
    endtask

    initial begin
        aresetn       = 1'b1;
        enable        = 1'b1;
        peak_index_i  = '0;
        peak_tdata_i  = '0;
        peak_tvalid_i = 1'b0;
        peak_index_q  = '0;
        peak_tdata_q  = '0;
        peak_tvalid_q = 1'b0;
        m_axis_tready = 1'b0;
        wrapSeen      = 0;
        modelReset();

        //            vi    vq    en    rdy   ii      di      iq      dq      ev    tdata                tuser
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 64'h1FF, 32'h0, 64'h0, 1'b0, 96'h0,               16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  64'h0,   32'h0, 64'h0, 1'b1, {32'h10, 64'h1FF},   16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  64'h0,   32'h0, 64'h0, 1'b0, 96'h0,               16'h0000};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 64'h2,   32'h30, 64'h3, 1'b0, 96'h0,              16'h0000};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  64'h0,   32'h0, 64'h0, 1'b1, {32'h20, 64'h2},     16'h0001};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  64'h0,   32'h0, 64'h0, 1'b1, {32'h30, 64'h3},     16'h8000};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  64'h0,   32'h0, 64'h0, 1'b0, 96'h0,               16'h0000};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h21, 64'h4,   32'h31, 64'h5, 1'b0, 96'h0,              16'h0000};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  64'h0,   32'h0, 64'h0, 1'b1, {32'h31, 64'h5},     16'h8001};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  64'h0,   32'h0, 64'h0, 1'b1, {32'h21, 64'h4},     16'h0002};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  64'h0,   32'h0, 64'h0, 1'b0, 96'h0,               16'h0000};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h50, 64'h8,   32'h51, 64'h9, 1'b0, 96'h0,              16'h0000};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  64'h0,   32'h0, 64'h0, 1'b0, 96'h0,               16'h0000};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 64'h6,   32'h0, 64'h0, 1'b0, 96'h0,               16'h0000};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h52, 64'hA,   32'h53, 64'hB, 1'b1, {32'h40, 64'h6},    16'h0003};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  64'h0,   32'h0, 64'h0, 1'b0, 96'h0,               16'h0000};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h41, 64'h7,   32'h0, 64'h0, 1'b0, 96'h0,               16'h0000};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  64'h0,   32'h0, 64'h0, 1'b1, {32'h41, 64'h7},     16'h0004};

        #3;
        resetDut();

        // Single result, simultaneous ties, enable low with draining.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].vi, vecs[i].vq, vecs[i].en, vecs[i].rdy,
                          vecs[i].ii, vecs[i].di, vecs[i].iq, vecs[i].dq);
            chk("vec_tvalid", 128'(m_axis_tvalid), 128'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk("vec_tdata", 128'(m_axis_tdata), 128'(vecs[i].etd));
                chk("vec_tuser", 128'(m_axis_tuser), 128'(vecs[i].etu));
            end
        end

        // Backpressure: six I pulses into a stalled output.
        resetDut();
        for (int k = 0; k < 6; k++)
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h100 + 32'(k), 64'(k), 32'h0, 64'h0);
        stepIdle(1'b0, 1'b1);
        stepIdle(1'b0, 1'b1);
        chk("bp_drop_i", 128'(drop_count_i), 128'(16'd1));
        chk("bp_hold_tdata", 128'(m_axis_tdata), 128'({32'h100, 64'h0}));
        for (int k = 0; k < 5; k++) begin
            chk("bp_seq", 128'(m_axis_tuser), 128'(16'(k)));
            stepIdle(1'b1, 1'b1);
        end
        chk("bp_empty", 128'(m_axis_tvalid), 128'(1'b0));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 64'h99, 32'h0, 64'h0);
        stepIdle(1'b1, 1'b1);
        chk("bp_next_seq", 128'(m_axis_tuser), 128'(16'd6));
        stepIdle(1'b1, 1'b1);

        // Sustained pulses on both channels.
        resetDut();
        for (int k = 0; k < 40; k++)
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'(k), 64'(k * 3), 32'(k + 1000), 64'(k * 5));
        for (int k = 0; k < 12; k++) stepIdle(1'b1, 1'b1);

        // Reset asserted while a report is stalled.
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h55, 64'h66, 32'h0, 64'h0);
        stepIdle(1'b0, 1'b1);
        chk("stall_tvalid", 128'(m_axis_tvalid), 128'(1'b1));
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h77, 64'h88, 32'h0, 64'h0);
        stepIdle(1'b1, 1'b1);
        chk("post_rst_tuser", 128'(m_axis_tuser), 128'(16'h0000));
        chk("post_rst_tdata", 128'(m_axis_tdata), 128'({32'h77, 64'h88}));
        stepIdle(1'b1, 1'b1);
        chk("post_rst_idle", 128'(m_axis_tvalid), 128'(1'b0));

        // Drop-counter saturation, with a short ready window around the seq wrap.
        resetDut();
        for (int k = 0; k < 32'h10020; k++)
            applyStimulus(1'b1, 1'b0, 1'b1, (k >= 32'h7FFD && k < 32'h7FFD + 12),
                          32'(k), 64'(k), 32'h0, 64'h0);
        chk("sat_drop_i", 128'(drop_count_i), 128'(16'hFFFF));
        for (int k = 0; k < 12; k++) stepIdle(1'b1, 1'b1);
        chk("wrap_seen", 128'(wrapSeen), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
